// File: rtl/gpio_irq_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gpio_irq_arbiter : round-robin arbiter that presents one GPIO interrupt at a
//                    time to the CPU and pulses the matching clear line.
// Revision 1.0
// ---------------------------------------------------------------------------
module gpio_irq_arbiter #(
    parameter int PIN_COUNT  = 32,
    parameter int CLEAR_WAIT = 2,
    localparam int VEC_W     = $clog2(PIN_COUNT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PIN_COUNT-1:0] int_status,
    input  logic [PIN_COUNT-1:0] int_mask,
    output logic [PIN_COUNT-1:0] int_clear,
    output logic                 irq_valid,
    output logic [VEC_W-1:0]     irq_vector,
    input  logic                 irq_ack,
    output logic                 irq_pending,
    output logic                 busy
);

    localparam int SUM_W = VEC_W + 1;
    localparam logic [SUM_W-1:0] c_PIN_SUM = SUM_W'(PIN_COUNT);
    localparam logic [VEC_W-1:0] c_LAST    = VEC_W'(PIN_COUNT - 1);
    localparam logic [VEC_W-1:0] c_ONE     = VEC_W'(1);
    localparam logic [3:0]       c_WAIT    = 4'(CLEAR_WAIT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_CLEAR = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [VEC_W-1:0]     r_vector;
    logic [VEC_W-1:0]     r_rr_ptr;
    logic [3:0]           r_cnt;
    logic [PIN_COUNT-1:0] w_req;
    logic                 w_found;
    logic [VEC_W-1:0]     w_pick;
    logic [SUM_W-1:0]     w_sum;

    assign w_req       = int_status & int_mask;
    assign irq_pending = |w_req;
    assign irq_valid   = (r_state == S_GRANT);
    assign busy        = (r_state != S_IDLE);
    assign irq_vector  = r_vector;

    // Upward search from r_rr_ptr; the sum is folded back so non-power-of-two
    // pin counts wrap correctly.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_sum   = '0;
        for (int i = 0; i < PIN_COUNT; i++) begin
            w_sum = {1'b0, r_rr_ptr} + SUM_W'(i);
            if (w_sum >= c_PIN_SUM) begin
                w_sum = w_sum - c_PIN_SUM;
            end
            if (!w_found && w_req[w_sum[VEC_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_sum[VEC_W-1:0];
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_next_state = S_GRANT;
            S_GRANT: begin
                if (irq_ack) begin
                    w_next_state = S_CLEAR;
                end else if (!w_req[r_vector]) begin
                    w_next_state = S_IDLE;
                end
            end
            S_CLEAR: w_next_state = S_WAIT;
            S_WAIT:  if (r_cnt <= 4'd1) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        int_clear = '0;
        if (r_state == S_CLEAR) begin
            int_clear[r_vector] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_vector <= '0;
            r_rr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: if (w_found) r_vector <= w_pick;
                S_CLEAR: begin
                    r_rr_ptr <= (r_vector == c_LAST) ? '0 : r_vector + c_ONE;
                    r_cnt    <= c_WAIT;
                end
                S_WAIT: if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gpio_irq_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_gpio_irq_arbiter : self-checking bench for gpio_irq_arbiter.
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_gpio_irq_arbiter;

    localparam int N  = 32;
    localparam int CW = 2;
    localparam logic [N-1:0] ALL = '1;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] int_status;
    logic [N-1:0] int_mask;
    logic [N-1:0] int_clear;
    logic         irq_valid;
    logic [4:0]   irq_vector;
    logic         irq_ack;
    logic         irq_pending;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a granted flag, the granted pin, the search start and
    // the number of post-acknowledge cycles still to run (clear + wait).
    bit m_grant;
    int m_vec;
    int m_ptr;
    int m_tail;

    gpio_irq_arbiter #(.PIN_COUNT(N), .CLEAR_WAIT(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .int_status (int_status),
        .int_mask   (int_mask),
        .int_clear  (int_clear),
        .irq_valid  (irq_valid),
        .irq_vector (irq_vector),
        .irq_ack    (irq_ack),
        .irq_pending(irq_pending),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    function automatic void model_reset();
        m_grant = 1'b0;
        m_vec   = 0;
        m_ptr   = 0;
        m_tail  = 0;
    endfunction

    function automatic void model_step();
        logic [N-1:0] req;
        req = int_status & int_mask;
        if (rst) begin
            model_reset();
        end else if (m_grant) begin
            if (irq_ack) begin
                m_grant = 1'b0;
                m_tail  = CW + 1;
                m_ptr   = (m_vec + 1) % N;
            end else if (!req[m_vec]) begin
                m_grant = 1'b0;
            end
        end else if (m_tail > 0) begin
            m_tail--;
        end else if (req != '0) begin
            for (int k = 0; k < N; k++) begin
                if (req[(m_ptr + k) % N]) begin
                    m_vec   = (m_ptr + k) % N;
                    m_grant = 1'b1;
                    break;
                end
            end
        end
    endfunction

    task automatic check_model(input string tag);
        logic [N-1:0] e_clr;
        logic         e_pend;
        logic         e_busy;
        e_clr = '0;
        if (!m_grant && m_tail == CW + 1) e_clr[m_vec] = 1'b1;
        e_pend = |(int_status & int_mask);
        e_busy = m_grant || (m_tail > 0);
        n_vec++;
        if (irq_valid !== m_grant || irq_vector !== 5'(m_vec) || int_clear !== e_clr ||
            busy !== e_busy || irq_pending !== e_pend) begin
            n_err++;
            $display("FAIL %s @%0t: got valid=%b vec=%0d clr=%h busy=%b pend=%b, want valid=%b vec=%0d clr=%h busy=%b pend=%b",
                     tag, $time, irq_valid, irq_vector, int_clear, busy, irq_pending,
                     m_grant, m_vec, e_clr, e_busy, e_pend);
        end
    endtask

    task automatic check_exp(input string tag, input logic v, input logic [4:0] vec,
                             input logic [N-1:0] clr, input logic b, input logic p);
        n_vec++;
        if (irq_valid !== v || irq_vector !== vec || int_clear !== clr ||
            busy !== b || irq_pending !== p) begin
            n_err++;
            $display("FAIL %s @%0t: got valid=%b vec=%0d clr=%h busy=%b pend=%b, want valid=%b vec=%0d clr=%h busy=%b pend=%b",
                     tag, $time, irq_valid, irq_vector, int_clear, busy, irq_pending, v, vec, clr, b, p);
        end
    endtask

    task automatic drive(input logic [N-1:0] st, input logic [N-1:0] mk, input logic ack);
        int_status = st;
        int_mask   = mk;
        irq_ack    = ack;
        #1;
        check_model("model");
    endtask

    task automatic clock();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic wait_valid(input logic [N-1:0] st, input logic [N-1:0] mk, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            drive(st, mk, 1'b0);
            if (irq_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            clock();
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL grant_timeout: got irq_valid=%b after 20 cycles, want 1", irq_valid);
        end
    endtask

    task automatic drain(input logic [N-1:0] st, input logic [N-1:0] mk);
        bit idle;
        idle = 1'b0;
        for (int k = 0; k < 20; k++) begin
            drive(st, mk, 1'b0);
            if (busy === 1'b0) begin
                idle = 1'b1;
                break;
            end
            clock();
        end
        if (!idle) begin
            n_vec++;
            n_err++;
            $display("FAIL idle_timeout: got busy=%b after 20 cycles, want 0", busy);
        end
    endtask

    task automatic serve(input string tag, input logic [N-1:0] st, input logic [N-1:0] mk,
                         input int exp_vec);
        bit ok;
        logic [N-1:0] e_clr;
        wait_valid(st, mk, ok);
        if (ok) begin
            n_vec++;
            if (irq_vector !== 5'(exp_vec)) begin
                n_err++;
                $display("FAIL %s: got vector=%0d, want %0d", tag, irq_vector, exp_vec);
            end
            drive(st, mk, 1'b1);
            clock();
            drive(st, mk, 1'b0);
            e_clr = '0;
            e_clr[exp_vec] = 1'b1;
            n_vec++;
            if (int_clear !== e_clr) begin
                n_err++;
                $display("FAIL %s_clear: got int_clear=%h, want %h", tag, int_clear, e_clr);
            end
            clock();
            drain(st, mk);
        end
    endtask

    task automatic do_reset(input logic [N-1:0] st);
        rst = 1'b1;
        model_reset();
        drive(st, ALL, 1'b0);
        clock();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0] st;
        logic [N-1:0] mk;
        logic         ack;
        logic         valid;
        logic [4:0]   vec;
        logic [N-1:0] clr;
        logic         busy;
        logic         pend;
    } vec_t;

    vec_t tbl[14];

    initial begin
        bit ok;
        rst        = 1'b1;
        int_status = '0;
        int_mask   = '0;
        irq_ack    = 1'b0;
        model_reset();

        tbl[0]  = '{32'h10, ALL, 1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 1'b1};
        tbl[1]  = '{32'h10, ALL, 1'b1, 1'b1, 5'd4, 32'h0,  1'b1, 1'b1};
        tbl[2]  = '{32'h10, ALL, 1'b0, 1'b0, 5'd4, 32'h10, 1'b1, 1'b1};
        tbl[3]  = '{32'h0,  ALL, 1'b0, 1'b0, 5'd4, 32'h0,  1'b1, 1'b0};
        tbl[4]  = '{32'h0,  ALL, 1'b0, 1'b0, 5'd4, 32'h0,  1'b1, 1'b0};
        tbl[5]  = '{32'h0,  ALL, 1'b0, 1'b0, 5'd4, 32'h0,  1'b0, 1'b0};
        tbl[6]  = '{32'h3,  32'h2, 1'b0, 1'b0, 5'd4, 32'h0, 1'b0, 1'b1};
        tbl[7]  = '{32'h3,  32'h2, 1'b0, 1'b1, 5'd1, 32'h0, 1'b1, 1'b1};
        tbl[8]  = '{32'h3,  32'h2, 1'b1, 1'b1, 5'd1, 32'h0, 1'b1, 1'b1};
        tbl[9]  = '{32'h1,  32'h2, 1'b0, 1'b0, 5'd1, 32'h2, 1'b1, 1'b0};
        tbl[10] = '{32'h1,  32'h2, 1'b0, 1'b0, 5'd1, 32'h0, 1'b1, 1'b0};
        tbl[11] = '{32'h1,  32'h2, 1'b0, 1'b0, 5'd1, 32'h0, 1'b1, 1'b0};
        tbl[12] = '{32'h1,  32'h2, 1'b0, 1'b0, 5'd1, 32'h0, 1'b0, 1'b0};
        tbl[13] = '{32'h1,  32'h2, 1'b0, 1'b0, 5'd1, 32'h0, 1'b0, 1'b0};

        repeat (2) @(negedge clk);
        drive('0, '0, 1'b0);
        check_exp("reset", 1'b0, 5'd0, '0, 1'b0, 1'b0);
        rst = 1'b0;

        // Single source then masking, cycle by cycle.
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].st, tbl[i].mk, tbl[i].ack);
            check_exp($sformatf("table[%0d]", i), tbl[i].valid, tbl[i].vec, tbl[i].clr,
                      tbl[i].busy, tbl[i].pend);
            clock();
        end

        // Round robin from a fresh pointer.
        do_reset('0);
        serve("rr0", 32'h8000_0003, ALL, 0);
        serve("rr1", 32'h8000_0003, ALL, 1);
        serve("rr31", 32'h8000_0003, ALL, 31);
        serve("rr0b", 32'h8000_0003, ALL, 0);

        // Wrap from pointer 31.
        serve("pin30", 32'h4000_0000, ALL, 30);
        serve("wrap0", 32'h0000_0005, ALL, 0);
        serve("wrap2", 32'h0000_0005, ALL, 2);

        // Withdrawal: pointer stays at 3, so pin 5 wins over pin 9.
        wait_valid(32'h80, ALL, ok);
        check_exp("wd_grant", 1'b1, 5'd7, '0, 1'b1, 1'b1);
        clock();
        drive('0, ALL, 1'b0);
        check_exp("wd_hold", 1'b1, 5'd7, '0, 1'b1, 1'b0);
        clock();
        drive('0, ALL, 1'b0);
        check_exp("wd_drop", 1'b0, 5'd7, '0, 1'b0, 1'b0);
        clock();
        serve("wd_ptr", 32'h220, ALL, 5);

        // Acknowledge and withdrawal together: acknowledge wins.
        wait_valid(32'h80, ALL, ok);
        clock();
        drive('0, ALL, 1'b1);
        clock();
        drive('0, ALL, 1'b0);
        check_exp("ack_drop", 1'b0, 5'd7, 32'h80, 1'b1, 1'b0);
        clock();
        drain('0, ALL);

        // Reset landing in the middle of a clear pulse.
        wait_valid(32'h10, ALL, ok);
        drive(32'h10, ALL, 1'b1);
        clock();
        drive(32'h10, ALL, 1'b0);
        check_exp("pre_rst_clear", 1'b0, 5'd4, 32'h10, 1'b1, 1'b1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_exp("rst_in_clear", 1'b0, 5'd0, '0, 1'b0, 1'b1);
        clock();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive('0, ALL, 1'b0);
            check_exp("post_rst", 1'b0, 5'd0, '0, 1'b0, 1'b0);
            clock();
        end

        // Arbitration on the first edge after release.
        do_reset(32'h10);
        drive(32'h10, ALL, 1'b0);
        clock();
        drive(32'h10, ALL, 1'b0);
        check_exp("first_edge", 1'b1, 5'd4, '0, 1'b1, 1'b1);
        clock();
        drive(32'h10, ALL, 1'b1);
        clock();
        drain('0, ALL);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            if (rst) model_reset();
            drive($urandom & $urandom & $urandom, $urandom | $urandom,
                  1'($urandom_range(0, 1)));
            clock();
        end
        rst = 1'b0;
        drive('0, ALL, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gpio_irq_arbiter.md
GPIO_IRQ_ARBITER -- requirements
Module: gpio_irq_arbiter

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter PIN_COUNT, default 32, SHALL give the number of GPIO interrupt sources; legal values are 2 to 64.
REQ-003 Parameter CLEAR_WAIT, default 2, SHALL give the number of idle cycles after a clear pulse, covering the clear-to-status-drop delay of the GPIO controller; legal values are 1 to 15.
REQ-004 Localparam VEC_W SHALL equal $clog2(PIN_COUNT).
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 int_status  in  PIN_COUNT  per-pin sticky interrupt status from the GPIO controller.
REQ-008 int_mask  in  PIN_COUNT  1 = pin takes part in arbitration.
REQ-009 int_clear  out  PIN_COUNT  one-hot, single-cycle clear pulse to the GPIO controller.
REQ-010 irq_valid  out  1  an interrupt vector is being presented to the CPU.
REQ-011 irq_vector  out  VEC_W  index of the granted pin.
REQ-012 irq_ack  in  1  CPU acknowledge; only sampled while irq_valid=1.
REQ-013 irq_pending  out  1  combinational OR of (int_status & int_mask).
REQ-014 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-015 The FSM SHALL have four states: IDLE, GRANT, CLEAR, WAIT.
REQ-016 In IDLE with (int_status & int_mask) != 0, the block SHALL pick the first set bit at or above rr_ptr, searching upward and wrapping from PIN_COUNT-1 to 0.
REQ-017 On that pick, the block SHALL latch the index into irq_vector and enter GRANT on the next edge; irq_valid rises exactly 1 cycle after the pending bit is seen in IDLE.
REQ-018 In GRANT, irq_valid SHALL be 1 and irq_vector SHALL stay stable until the state is left.
REQ-019 In GRANT with irq_ack=1, the block SHALL enter CLEAR; irq_ack has priority over withdrawal when both occur in the same cycle.
REQ-020 In GRANT with irq_ack=0 and the granted bit of (int_status & int_mask) low (withdrawal), the block SHALL return to IDLE with no clear pulse and rr_ptr unchanged.
REQ-021 In CLEAR, for exactly 1 cycle, int_clear SHALL equal 1<<irq_vector and irq_valid SHALL be 0.
REQ-022 In CLEAR, rr_ptr SHALL be set to irq_vector+1, wrapping to 0 when irq_vector = PIN_COUNT-1.
REQ-023 From CLEAR the block SHALL enter WAIT and load a counter with CLEAR_WAIT.
REQ-024 In WAIT the counter SHALL decrement each cycle, and the block SHALL return to IDLE in the cycle the counter reaches 1; WAIT lasts exactly CLEAR_WAIT cycles.
REQ-025 No arbitration SHALL occur outside IDLE; new pending bits wait for IDLE.
REQ-026 int_clear SHALL be all-zero in every state except CLEAR.
REQ-027 irq_ack seen outside GRANT SHALL be ignored.
REQ-028 The minimum back-to-back service period SHALL be 3+CLEAR_WAIT cycles, counted from irq_valid rising to irq_valid rising again.

Reset
REQ-029 While rst=1 the outputs SHALL be: state IDLE, irq_valid=0, irq_vector=0, int_clear=0, busy=0, rr_ptr=0, counter=0.
REQ-030 Reset asserted mid-operation, including during CLEAR, SHALL abort at once: any in-progress int_clear pulse is cut, and no pulse is issued after rst falls.
REQ-031 After rst deasserts, arbitration SHALL begin on the first clock edge.

Verification
REQ-032 Single source: PIN_COUNT=32, status=0x0000_0010, mask=all ones -> irq_valid rises 1 cycle later with vector=4; ack -> int_clear=0x10 for 1 cycle; busy low after CLEAR_WAIT=2 further cycles.
REQ-033 Round robin: status=0x8000_0003 held (re-asserted after each clear), acked each time -> vectors served in order 0, 1, 31, 0.
REQ-034 Wrap: rr_ptr=31 after serving pin 30, status=0x0000_0005 -> vector=0, then vector=2.
REQ-035 Withdrawal: grant on pin 7, then status[7] drops with ack=0 -> irq_valid falls next cycle, int_clear stays 0, rr_ptr unchanged; ack and drop in the same cycle -> CLEAR issued with int_clear=0x80.
REQ-036 Masking: status=0x3, mask=0x2 -> only vector 1 is presented; bit 0 is never granted.
REQ-037 Reset in CLEAR: rst=1 during the int_clear pulse -> int_clear=0 immediately and all outputs at reset values; no clear pulse after release.
